aes128_inv_mix_columns_seq: RTL
===============================

# aes128_inv_mix_columns_seq

Iterative AES-128 InvMixColumns unit for the decryption datapath: the inverse of the forward MixColumns stage. It accepts a 128-bit state via valid/ready, transforms one 32-bit column per clock in a working register, and returns the result via valid/ready. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop and trades latency for roughly a quarter of the combinational GF(2^8) logic of a full-width implementation.

## Interface
- No parameters. Column parallelism is chosen by the macro under Configuration.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  state_in is valid.
- in_ready  out  1  block accepts state_in this cycle.
- state_in  in  128  input state. Column i = bits [i*32+31:i*32]; row 0 byte = [i*32+31:i*32+24], row 3 byte = [i*32+7:i*32].
- out_valid  out  1  state_out holds the finished result.
- out_ready  in  1  downstream accepts state_out.
- state_out  out  128  result, same byte layout as state_in.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Per column (a0..a3 = rows 0..3):
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1. xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits. 09/0b/0d/0e are built from the xtime chain x2, x4, x8 plus XORs. Addition is XOR.
- FSM with three states:
  - IDLE: in_ready=1. On in_valid, load state_in into the working register, set col=0, and go to RUN.
  - RUN: transform column col in place and increment col. When col==3, wrap col to 0 and go to DONE. in_ready=0.
  - DONE: out_valid=1 and state_out = working register. On out_ready with in_valid low, go to IDLE. On out_ready with in_valid high, load the new state, set col=0, and go to RUN (back-to-back transfer).
- in_ready = IDLE || (DONE && out_ready). in_ready depends combinationally on out_ready; there is no combinational path from in_valid to out_valid.
- Inputs while not ready are ignored. state_in is sampled only on the accepting edge.
- If out_ready is held low, DONE holds indefinitely and state_out stays stable.
- Asynchronous reset mid-operation: go to IDLE immediately, discard the working register, and set col=0.

## Timing
- Reset values: out_valid=0, busy=0, state_out=128'h0, working register=0, col=0, FSM=IDLE. in_ready=1 once reset is deasserted.
- Latency: input accepted at edge N; columns processed at edges N+1..N+4; out_valid asserted after edge N+4.
- Throughput: one block per 5 cycles with out_ready held high. Back-to-back acceptance happens in the DONE cycle.
- state_out is driven straight from a register, with no output combinational logic.

## Configuration
- AES_INV_MC_DUAL_COL_EN, when defined:
  - Two columns are transformed per cycle: (0,1), then (2,3).
  - col steps 0 then 2; RUN lasts 2 cycles; out_valid follows acceptance by 2 edges.
  - Two instances of the column sub-module.
- When undefined: one column per cycle, 4-cycle RUN, one instance.
- The handshake, reset values and results are identical in both builds.

## Structure
- Shared package aes128_pkg holds:
  - the xtime and gf_mul9/0b/0d/0e functions, with the reduction constant 8'h1b;
  - the state, column and byte width constants;
  - the FSM state enum {IDLE, RUN, DONE}.
- Sub-module aes128_inv_mix_column: purely combinational, 32-bit column in and 32-bit column out. The top level holds the FSM, the column counter, the working register and the instance mux.

## Test plan
- Single column: state_in = {8e4da1bc, 9fdc589d, 01010101, 4d7ebdf8} (column 3..0), out_ready=1 -> after 4 RUN cycles (2 with the macro), state_out = {db135345, f20a225c, 01010101, 2d26314c} and out_valid pulses for 1 cycle.
- Identity and fixed points: 128'h0 -> 128'h0. All bytes c6 -> all bytes c6. Column d5d5d7d6 -> d4d4d4d5.
- Backpressure: out_ready=0 for 10 cycles after DONE -> out_valid stays 1, state_out stable, in_ready=0. Raising out_ready together with in_valid accepts the next block in the same cycle.
- Back-to-back: 3 blocks with in_valid and out_ready tied high -> 3 correct results, accepts spaced 5 cycles (3 with the macro).
- Reset mid-RUN: assert rst_n=0 at col==2 -> out_valid=0, busy=0 and state_out=0 immediately. After release, a new block produces the correct result.
- Round trip: 1000 random states through the forward MixColumns then this block -> output equals the original input.

Source files
------------

// File: rtl/aes128_inv_mix_columns_seq_pkg.sv
// aes128_pkg: shared GF(2^8) helpers, width constants and FSM state type for InvMixColumns
package aes128_pkg;
  localparam int STATE_W = 128;
  localparam int COL_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] GF_POLY = 8'h1b;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction
  function automatic logic [BYTE_W-1:0] gf_mul09(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction
  function automatic logic [BYTE_W-1:0] gf_mul0b(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction
  function automatic logic [BYTE_W-1:0] gf_mul0d(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction
  function automatic logic [BYTE_W-1:0] gf_mul0e(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
endpackage

// File: rtl/aes128_inv_mix_columns_seq_if.sv
// aes128_inv_mix_columns_seq_if: input/output valid-ready bus of the InvMixColumns unit
interface aes128_inv_mix_columns_seq_if;
  import aes128_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [STATE_W-1:0] state_in;
  logic out_valid;
  logic out_ready;
  logic [STATE_W-1:0] state_out;
  logic busy;
  modport master (output in_valid, state_in, out_ready, input in_ready, out_valid, state_out, busy);
  modport slave (input in_valid, state_in, out_ready, output in_ready, out_valid, state_out, busy);
endinterface

// File: rtl/aes128_inv_mix_columns_seq_col.sv
// aes128_inv_mix_column: combinational InvMixColumns of one 32-bit column (row 0 in the top byte)
module aes128_inv_mix_column
  import aes128_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);
  logic [BYTE_W-1:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3),
                  gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3),
                  gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3),
                  gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3)};
endmodule

// File: rtl/aes128_inv_mix_columns_seq.sv
// aes128_inv_mix_columns_seq: iterative InvMixColumns, one column per cycle or two with AES_INV_MC_DUAL_COL_EN
module aes128_inv_mix_columns_seq
  import aes128_pkg::*;
(
  input logic clk,
  input logic rst_n,
  aes128_inv_mix_columns_seq_if.slave bus
);
`ifdef AES_INV_MC_DUAL_COL_EN
  localparam int NCOL = 2;
`else
  localparam int NCOL = 1;
`endif
  localparam logic [1:0] COL_STEP = 2'(NCOL);
  localparam logic [1:0] COL_LAST = 2'(4 - NCOL);
  state_e state_q;
  logic [1:0] col_q;
  logic [3:0][COL_W-1:0] work_q, work_d;
  logic [NCOL-1:0][COL_W-1:0] cin, cout;
  logic out_valid_q, busy_q, accept;
  for (genvar g = 0; g < NCOL; g++) begin : g_col
    assign cin[g] = work_q[col_q + 2'(g)];
    aes128_inv_mix_column u_col (.col_i(cin[g]), .col_o(cout[g]));
  end
  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.busy = busy_q;
  assign bus.state_out = work_q;
  // write the transformed column(s) back into their slots of the working state
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < NCOL; i++) work_d[col_q + 2'(i)] = cout[i];
  end
  // control FSM; col wraps to 0 naturally on the final step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      col_q <= '0;
      work_q <= '0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (accept) begin
      work_q <= bus.state_in;
      col_q <= '0;
      state_q <= RUN;
      busy_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      work_q <= work_d;
      col_q <= col_q + COL_STEP;
      if (col_q == COL_LAST) begin
        state_q <= DONE;
        out_valid_q <= 1'b1;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      out_valid_q <= 1'b0;
    end
endmodule
